cdb_broadcaster: RTL and testbench

Producer end of the common data bus that the reservation stations consume. Collects completed results from NUM_FU functional units and registers each result into a per-ROB-tag CDB entry. Sets the matching robs_calculated bit. Clears entries on ROB allocation, commit, and flush, so a stale result never looks valid to a waiting reservation station.

---
 rtl/cdb_broadcaster.sv | 112 +++++++++++
 tb/tb_cdb_broadcaster.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_broadcaster.sv
// Common data bus broadcaster: registers functional-unit results into per-ROB-tag
// entries and exposes valid / freshly-written masks to the reservation stations.
//
// state | meaning
// ------+------------------------------------------------------------
// (none)| no FSM; each tag entry is an independent valid/data register
//
// Per-tag update priority: flush (tag not live) > allocation > FU write > commit.
// FU writes to a cleared tag are dropped and flagged, so a stale result never
// looks valid to a waiting reservation station.
module cdb_broadcaster #(
  parameter int NUM_FU   = 4,
  parameter int NUM_TAGS = 8,
  parameter int TAG_W    = 3,
  parameter int DATA_W   = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_FU-1:0]          fu_valid,
  input  logic [NUM_FU*TAG_W-1:0]    fu_tag,
  input  logic [NUM_FU*DATA_W-1:0]   fu_data,
  input  logic [NUM_FU*DATA_W-1:0]   fu_pc,
  input  logic [NUM_FU-1:0]          fu_ld_pc,
  input  logic                       rob_alloc,
  input  logic [TAG_W-1:0]           rob_alloc_tag,
  input  logic                       rob_commit,
  input  logic [TAG_W-1:0]           rob_commit_tag,
  input  logic [NUM_TAGS-1:0]        allocated_rob_entries,
  output logic [NUM_TAGS*DATA_W-1:0] cdb_data,
  output logic [NUM_TAGS-1:0]        robs_calculated,
  output logic [NUM_TAGS-1:0]        cdb_new,
  output logic                       collision_err,
  output logic                       dup_err
);

  logic [NUM_TAGS-1:0][DATA_W-1:0] data_q, data_d;
  logic [NUM_TAGS-1:0]             valid_q, valid_d;
  logic [NUM_TAGS-1:0]             new_q, new_d;
  logic                            col_q, col_d;
  logic                            dup_q, dup_d;

  // Next-state for every tag entry: pick the lowest-index FU targeting the tag,
  // then apply flush / allocate / write / commit in priority order.
  always_comb begin
    logic              hit;
    logic [DATA_W-1:0] win_val;
    data_d  = data_q;
    valid_d = valid_q;
    new_d   = '0;
    col_d   = col_q;
    dup_d   = dup_q;
    hit     = 1'b0;
    win_val = '0;
    for (int t = 0; t < NUM_TAGS; t++) begin
      hit     = 1'b0;
      win_val = '0;
      for (int i = 0; i < NUM_FU; i++) begin
        if (fu_valid[i] && (fu_tag[i*TAG_W +: TAG_W] == TAG_W'(t))) begin
          if (hit) begin
            col_d = 1'b1;
          end else begin
            hit     = 1'b1;
            win_val = fu_ld_pc[i] ? (fu_pc[i*DATA_W +: DATA_W] + DATA_W'(4))
                                  : fu_data[i*DATA_W +: DATA_W];
          end
        end
      end

      if (!allocated_rob_entries[t]) begin
        valid_d[t] = 1'b0;
        data_d[t]  = '0;
        if (hit) dup_d = 1'b1;
      end else if (rob_alloc && (rob_alloc_tag == TAG_W'(t))) begin
        valid_d[t] = 1'b0;
        data_d[t]  = '0;
        if (hit) dup_d = 1'b1;
      end else if (hit) begin
        if (valid_q[t]) dup_d = 1'b1;
        valid_d[t] = 1'b1;
        data_d[t]  = win_val;
        new_d[t]   = 1'b1;
      end else if (rob_commit && (rob_commit_tag == TAG_W'(t))) begin
        // Data is left in place; only the valid bit matters after retirement.
        valid_d[t] = 1'b0;
      end
    end
  end

  // Entry and flag registers; synchronous reset discards every entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= '0;
      new_q   <= '0;
      col_q   <= 1'b0;
      dup_q   <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      new_q   <= new_d;
      col_q   <= col_d;
      dup_q   <= dup_d;
    end
  end

  assign cdb_data        = data_q;
  assign robs_calculated = valid_q;
  assign cdb_new         = new_q;
  assign collision_err   = col_q;
  assign dup_err         = dup_q;

endmodule

// File: tb/tb_cdb_broadcaster.sv
// Scoreboard bench for cdb_broadcaster: the driver pushes the reference model's
// expected post-edge state each cycle; the monitor pops and compares after each edge.
module tb_cdb_broadcaster;

  localparam int NF = 4;
  localparam int NT = 8;
  localparam int TW = 3;
  localparam int DW = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic [NF-1:0]     fu_valid;
  logic [NF*TW-1:0]  fu_tag;
  logic [NF*DW-1:0]  fu_data;
  logic [NF*DW-1:0]  fu_pc;
  logic [NF-1:0]     fu_ld_pc;
  logic              rob_alloc;
  logic [TW-1:0]     rob_alloc_tag;
  logic              rob_commit;
  logic [TW-1:0]     rob_commit_tag;
  logic [NT-1:0]     allocated_rob_entries;
  logic [NT*DW-1:0]  cdb_data;
  logic [NT-1:0]     robs_calculated;
  logic [NT-1:0]     cdb_new;
  logic              collision_err;
  logic              dup_err;

  cdb_broadcaster #(.NUM_FU(NF), .NUM_TAGS(NT), .TAG_W(TW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .fu_valid(fu_valid), .fu_tag(fu_tag), .fu_data(fu_data), .fu_pc(fu_pc),
    .fu_ld_pc(fu_ld_pc),
    .rob_alloc(rob_alloc), .rob_alloc_tag(rob_alloc_tag),
    .rob_commit(rob_commit), .rob_commit_tag(rob_commit_tag),
    .allocated_rob_entries(allocated_rob_entries),
    .cdb_data(cdb_data), .robs_calculated(robs_calculated), .cdb_new(cdb_new),
    .collision_err(collision_err), .dup_err(dup_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NT-1:0]    valid;
    logic [NT-1:0]    newv;
    logic [NT*DW-1:0] data;
    logic             col;
    logic             dup;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // reference model state
  bit          m_valid[NT];
  logic [31:0] m_data[NT];
  bit          m_col;
  bit          m_dup;

  function automatic void check(string name, logic [NT*DW-1:0] act, logic [NT*DW-1:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endfunction

  // Monitor: after each active edge, compare the DUT with the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("robs_calculated", NT*DW'(robs_calculated), NT*DW'(e.valid));
        check("cdb_new", NT*DW'(cdb_new), NT*DW'(e.newv));
        check("cdb_data", cdb_data, e.data);
        check("collision_err", NT*DW'(collision_err), NT*DW'(e.col));
        check("dup_err", NT*DW'(dup_err), NT*DW'(e.dup));
      end
    end
  end

  // Reference model: apply the currently driven inputs and queue the result.
  task automatic model_step();
    exp_t        e;
    bit          claimed[NT];
    logic [31:0] wval[NT];
    int          t;
    e.newv = '0;
    for (int k = 0; k < NT; k++) begin
      claimed[k] = 0;
      wval[k] = '0;
    end
    if (rst) begin
      for (int k = 0; k < NT; k++) begin
        m_valid[k] = 0;
        m_data[k] = '0;
      end
      m_col = 0;
      m_dup = 0;
    end else begin
      for (int i = 0; i < NF; i++) begin
        if (fu_valid[i]) begin
          t = int'(fu_tag[i*TW +: TW]);
          if (claimed[t]) m_col = 1;
          else begin
            claimed[t] = 1;
            wval[t] = fu_ld_pc[i] ? fu_pc[i*DW +: DW] + 32'd4 : fu_data[i*DW +: DW];
          end
        end
      end
      for (int k = 0; k < NT; k++) begin
        if (!allocated_rob_entries[k] || (rob_alloc && int'(rob_alloc_tag) == k)) begin
          m_valid[k] = 0;
          m_data[k] = '0;
          if (claimed[k]) m_dup = 1;
        end else if (claimed[k]) begin
          if (m_valid[k]) m_dup = 1;
          m_valid[k] = 1;
          m_data[k] = wval[k];
          e.newv[k] = 1'b1;
        end else if (rob_commit && int'(rob_commit_tag) == k) begin
          m_valid[k] = 0;
        end
      end
    end
    for (int k = 0; k < NT; k++) begin
      e.valid[k] = m_valid[k];
      e.data[k*DW +: DW] = m_data[k];
    end
    e.col = m_col;
    e.dup = m_dup;
    exp_q.push_back(e);
  endtask

  task automatic idle_inputs();
    fu_valid = '0; fu_tag = '0; fu_data = '0; fu_pc = '0; fu_ld_pc = '0;
    rob_alloc = 0; rob_alloc_tag = '0; rob_commit = 0; rob_commit_tag = '0;
  endtask

  task automatic set_fu(int i, int tag, logic [31:0] d, bit ld, logic [31:0] pc);
    fu_valid[i] = 1'b1;
    fu_tag[i*TW +: TW] = TW'(tag);
    fu_data[i*DW +: DW] = d;
    fu_ld_pc[i] = ld;
    fu_pc[i*DW +: DW] = pc;
  endtask

  // One cycle: model the driven inputs, then advance to the next falling edge.
  task automatic cycle();
    model_step();
    @(negedge clk);
    idle_inputs();
  endtask

  function automatic logic [31:0] entry(int t);
    return cdb_data[t*DW +: DW];
  endfunction

  initial begin
    rst = 1;
    allocated_rob_entries = 8'hFF;
    idle_inputs();
    cycle();
    cycle();
    rst = 0;
    cycle();
    check("reset_calc", NT*DW'(robs_calculated), '0);
    check("reset_data", cdb_data, '0);

    set_fu(0, 3, 32'hDEADBEEF, 0, 32'h0);
    cycle();
    check("t3_calc", NT*DW'(robs_calculated), NT*DW'(8'h08));
    check("t3_new", NT*DW'(cdb_new), NT*DW'(8'h08));
    check("t3_data", NT*DW'(entry(3)), NT*DW'(32'hDEADBEEF));
    cycle();
    check("t3_new_gone", NT*DW'(cdb_new), '0);
    check("t3_hold", NT*DW'(entry(3)), NT*DW'(32'hDEADBEEF));

    set_fu(1, 5, 32'h1234, 1, 32'hFFFFFFFC);
    cycle();
    check("ldpc_wrap", NT*DW'(entry(5)), '0);
    check("ldpc_calc", NT*DW'(robs_calculated[5]), NT*DW'(1'b1));

    set_fu(0, 2, 32'd11, 0, 0);
    set_fu(2, 2, 32'd22, 0, 0);
    cycle();
    check("collide_data", NT*DW'(entry(2)), NT*DW'(32'd11));
    check("collide_flag", NT*DW'(collision_err), NT*DW'(1'b1));

    set_fu(0, 1, 32'h101, 0, 0);
    set_fu(1, 6, 32'h606, 0, 0);
    cycle();
    check("dup_before", NT*DW'(dup_err), '0);
    allocated_rob_entries = 8'hBD;
    set_fu(0, 6, 32'h777, 0, 0);
    cycle();
    check("flush_bits", NT*DW'(robs_calculated & 8'h42), '0);
    check("flush_dup", NT*DW'(dup_err), NT*DW'(1'b1));
    allocated_rob_entries = 8'hFF;

    rob_commit = 1; rob_commit_tag = 3'd4;
    set_fu(3, 4, 32'd7, 0, 0);
    cycle();
    check("commit_vs_write", NT*DW'(robs_calculated[4]), NT*DW'(1'b1));
    check("commit_data", NT*DW'(entry(4)), NT*DW'(32'd7));
    rob_alloc = 1; rob_alloc_tag = 3'd4;
    cycle();
    check("alloc_clear", NT*DW'(robs_calculated[4]), '0);
    check("collide_sticky", NT*DW'(collision_err), NT*DW'(1'b1));

    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 59) == 0);
      allocated_rob_entries = ($urandom_range(0, 3) == 0) ?
                              ~(NT'(1) << $urandom_range(0, NT - 1)) : 8'hFF;
      for (int i = 0; i < NF; i++) begin
        if ($urandom_range(0, 1) == 1)
          set_fu(i, int'($urandom_range(0, NT - 1)), $urandom,
                 $urandom_range(0, 3) == 0,
                 ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFC : $urandom);
      end
      rob_alloc = ($urandom_range(0, 3) == 0);
      rob_alloc_tag = TW'($urandom_range(0, NT - 1));
      rob_commit = ($urandom_range(0, 3) == 0);
      rob_commit_tag = TW'($urandom_range(0, NT - 1));
      cycle();
    end

    rst = 1;
    cycle();
    rst = 0;
    check("midrst_calc", NT*DW'(robs_calculated), '0);
    check("midrst_flags", NT*DW'({collision_err, dup_err}), '0);

    for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(negedge clk);
    if (exp_q.size() > 0) begin
      bad++;
      total++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
